// File: rtl/vector_rotator.sv
// vector_rotator: rotates a signed 16-bit (x, y) by an integer-degree angle using external cos/sin lookup data.
// Optional build macro VECTOR_ROTATOR_ROUND_EN selects round-half-up instead of truncation before saturation.
module vector_rotator #(
    parameter int LOOKUP_LATENCY = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic [15:0] x_in,
    input  logic [15:0] y_in,
    input  logic [15:0] angle_in,
    output logic [15:0] angle_out,
    input  logic [15:0] cos_abs_in,
    input  logic [15:0] sin_abs_in,
    input  logic        cos_sign_in,
    input  logic        sin_sign_in,
    output logic        valid_out,
    input  logic        ready_in,
    output logic [15:0] x_out,
    output logic [15:0] y_out
);
    typedef enum logic [2:0] {IDLE, REDUCE, LOOKUP, SUM, DONE} state_t;

    localparam int CW = LOOKUP_LATENCY > 1 ? $clog2(LOOKUP_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LOOKUP_LATENCY - 1);
`ifdef VECTOR_ROTATOR_ROUND_EN
    localparam logic signed [33:0] RND = 34'sd16384;
`else
    localparam logic signed [33:0] RND = 34'sd0;
`endif

    state_t state_q, state_d;
    logic run_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0] angle_q, angle_d;
    logic signed [15:0] x_q, x_d, y_q, y_d, xo_q, xo_d, yo_q, yo_d;
    logic signed [32:0] xc_q, ys_q, xs_q, yc_q;
    logic signed [16:0] c_s, s_s;
    logic signed [33:0] sum_x, sum_y;
    logic accept, sample;

    function automatic logic signed [15:0] sat(input logic signed [33:0] v);
        logic signed [33:0] s;
        s = v >>> 15;
        return s > 34'sd32767 ? 16'sh7fff : s < -34'sd32768 ? 16'sh8000 : s[15:0];
    endfunction

    assign ready_out = run_q && state_q == IDLE;
    assign valid_out = state_q == DONE;
    assign accept    = valid_in && ready_out;
    assign sample    = state_q == LOOKUP && cnt_q == CNT_LAST;
    assign angle_out = angle_q;
    assign x_out     = xo_q;
    assign y_out     = yo_q;

    // sign bits are applied exactly as delivered by the lookup
    assign c_s = cos_sign_in ? $signed({1'b0, cos_abs_in}) : -$signed({1'b0, cos_abs_in});
    assign s_s = sin_sign_in ? $signed({1'b0, sin_abs_in}) : -$signed({1'b0, sin_abs_in});

    assign sum_x = 34'(xc_q) - 34'(ys_q) + RND;
    assign sum_y = 34'(xs_q) + 34'(yc_q) + RND;
    assign xo_d  = state_q == SUM ? sat(sum_x) : xo_q;
    assign yo_d  = state_q == SUM ? sat(sum_y) : yo_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        angle_d = angle_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = REDUCE;
                x_d     = x_in;
                y_d     = y_in;
                angle_d = angle_in;
            end
            REDUCE: if (angle_q >= 16'd360) begin
                angle_d = angle_q - 16'd360;
            end else begin
                cnt_d   = '0;
                state_d = LOOKUP;
            end
            LOOKUP: if (sample) state_d = SUM; else cnt_d = cnt_q + CW'(1);
            SUM:    state_d = DONE;
            DONE:   if (ready_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
            cnt_q   <= '0;
            angle_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            xo_q    <= '0;
            yo_q    <= '0;
            xc_q    <= '0;
            ys_q    <= '0;
            xs_q    <= '0;
            yc_q    <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            cnt_q   <= cnt_d;
            angle_q <= angle_d;
            x_q     <= x_d;
            y_q     <= y_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            if (sample) begin
                xc_q <= 33'(x_q) * 33'(c_s);
                ys_q <= 33'(y_q) * 33'(s_s);
                xs_q <= 33'(x_q) * 33'(s_s);
                yc_q <= 33'(y_q) * 33'(c_s);
            end
        end
    end
endmodule

// File: doc/vector_rotator.md
# vector_rotator

Rotates a signed 16-bit 2-D vector (x, y) by an integer-degree angle using the sign/magnitude cosine and sine produced by `cos_sin_lookup`. It is the direct consumer of the lookup. It reduces the angle into 0..359, drives the lookup's `angle` input, and waits out the lookup's fixed read latency. It then forms x' = x·cos − y·sin and y' = x·sin + y·cos and presents the result on a valid/ready output handshake.

## Interface
- `LOOKUP_LATENCY`, default 2: cycles from the angle being sampled by the lookup to its data being valid.
- `clk_in` input 1: clock.
- `rst_n_in` input 1: asynchronous, active-low reset.
- `valid_in` input 1: request valid.
- `ready_out` output 1: block can accept; high only in IDLE.
- `x_in`, `y_in` input 16 each: signed vector components.
- `angle_in` input 16: unsigned angle in degrees, any value 0..65535.
- `angle_out` output 16: to lookup `angle`; always in 0..359 when used.
- `cos_abs_in`, `sin_abs_in` input 16 each: unsigned magnitudes, 16'h8000 = 1.0.
- `cos_sign_in`, `sin_sign_in` input 1 each: 1 = positive, 0 = negative.
- `valid_out` output 1: result valid.
- `ready_in` input 1: downstream accepts.
- `x_out`, `y_out` output 16 each: signed rotated components.

## Operation
- FSM states: IDLE, REDUCE, LOOKUP, SUM, DONE.
- **IDLE**
  - `ready_out` = 1.
  - On `valid_in & ready_out`, register `x_in`, `y_in`, `angle_in` into `angle_r`, then go to REDUCE.
- **REDUCE**
  - If `angle_r` ≥ 360, subtract 360 from `angle_r` and stay in REDUCE. Each subtraction costs one cycle, up to 182 cycles for 65535.
  - Otherwise, clear the wait counter and go to LOOKUP.
- **LOOKUP**
  - Stay for exactly `LOOKUP_LATENCY` cycles.
  - On the edge ending the last LOOKUP cycle, sample the lookup outputs.
  - Convert each magnitude to a 17-bit signed value: the magnitude if its sign is 1, its negation if 0.
  - Register four 33-bit signed products: x·c, y·s, x·s, y·c.
- **SUM**
  - Compute 34-bit sums: X = x·c − y·s and Y = x·s + y·c.
  - Arithmetic-shift each right by 15, saturate to the range −32768..32767, and register into `x_out`/`y_out`.
  - Go to DONE.
- **DONE**
  - `valid_out` = 1, with `x_out`/`y_out` held stable.
  - On `ready_in`, go to IDLE.
- `angle_out` = `angle_r` at all times. It is constant from REDUCE exit until the LOOKUP sample edge.
- Sign inputs are used exactly as received; the block never re-derives quadrant signs.

## Timing
- Reset values: `ready_out` = 0; `valid_out` = 0; `x_out` = `y_out` = 0; `angle_out` = 0; state IDLE.
- `ready_out` rises on the first clock edge after `rst_n_in` deasserts.
- Latency, acceptance edge to `valid_out` high: `LOOKUP_LATENCY` + 3 + k cycles, where k is the number of subtractions. With default L = 2 and angle < 360, this is 5 cycles.
- Throughput: one vector per (latency + 1) cycles when `ready_in` stays high.
  - `ready_out` is low outside IDLE, and DONE→IDLE costs one cycle.
- Backpressure: `valid_out` and the data hold indefinitely while `ready_in` = 0.
- Boundary angles:
  - 360 reduces to 0.
  - 359 needs no reduction.
  - 65535 reduces to 15 after 182 cycles.
- Reset mid-operation: immediate return to reset values and IDLE. No partial result is ever emitted.
- `valid_in` outside IDLE is ignored; its data is not captured.

## Configuration
- `VECTOR_ROTATOR_ROUND_EN` defined: add 2^14 to X and Y before the shift (round half up), then saturate.
- Undefined: plain arithmetic shift (truncate toward −∞).
- Latency is identical in both builds.

## Test plan
- Angle 0, x = 1000, y = 0, lookup model (cos 16'h8000 +, sin 0 +) → x_out = 1000, y_out = 0, `valid_out` 5 cycles after accept.
- Angle 450, x = 1000, y = 0, model (cos 0 +, sin 16'h8000 +) → `angle_out` = 90, x_out = 0, y_out = 1000, `valid_out` 6 cycles after accept.
- Angle 45, x = y = 32767, model (cos 16'h5A82 +, sin 16'h5A82 +) → x_out = 0, y_out saturates to 32767.
- Angle 0, x = 1, y = 0, model (cos 16'h4000 +, sin 0 +) → x_out = 0 without `VECTOR_ROTATOR_ROUND_EN`, 1 with it.
- Backpressure: hold `ready_in` = 0 for 3 cycles in DONE → outputs stable and `valid_out` high; `ready_out` rises 1 cycle after `ready_in` = 1.
- Reset: assert `rst_n_in` = 0 during LOOKUP → `valid_out` = 0 and outputs 0 immediately; a fresh request after release completes normally.
